// File: rtl/e203_irq_stim_mon.sv
// Interrupt stimulus generator and completion monitor: drives CH_NUM interrupt lines with
// LFSR-randomised gaps, holds each until its handler-exit PC commits, and reports per-channel stats.
module e203_irq_stim_mon #(
  parameter int          CH_NUM = 3,
  parameter int          PC_W   = 32,
  parameter int          DLY_W  = 10,
  parameter int          LAT_W  = 16,
  parameter int          CNT_W  = 32,
  parameter logic [31:0] SEED   = 32'h1
) (
  input  logic                     hfclk,
  input  logic                     rst_n,
  input  logic                     cmt_valid,
  input  logic [PC_W-1:0]          cmt_pc,
  input  logic [PC_W-1:0]          arm_pc,
  input  logic [CH_NUM*PC_W-1:0]   ack_pc,
  input  logic [DLY_W-1:0]         dly_mask,
  input  logic                     stop_req,
  output logic [CH_NUM-1:0]        irq_o,
  output logic                     armed_o,
  output logic                     idle_o,
  output logic [CH_NUM*CNT_W-1:0]  inj_cnt,
  output logic [CH_NUM*LAT_W-1:0]  lat_max,
  output logic [CH_NUM-1:0]        tmo_err
);

  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [31:0] SEED_INIT = (SEED == 32'h0) ? 32'h1 : SEED;

  localparam logic [1:0] ST_DISARM = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ASSERT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic              armed_reg;
  logic [31:0]       lfsr_reg;
  logic [31:0]       lfsr_next;
  logic [CH_NUM-1:0] ch_idle;

  assign lfsr_next = {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? LFSR_MASK : 32'h0);

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      armed_reg <= 1'b0;
      lfsr_reg  <= SEED_INIT;
    end else begin
      if (cmt_valid && (cmt_pc == arm_pc)) armed_reg <= 1'b1;
      if (armed_reg) lfsr_reg <= lfsr_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      // Each channel sees the shared LFSR rotated by a different amount to decorrelate gaps.
      localparam int ROT = (7 * gi) % 32;

      logic [1:0]       st_reg;
      logic [DLY_W:0]   gap_reg;
      logic [DLY_W:0]   gap_new;
      logic [DLY_W-1:0] rot_bits;
      logic [LAT_W-1:0] lat_reg;
      logic [LAT_W-1:0] lat_max_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             irq_reg;
      logic             tmo_reg;
      logic             ack;

      assign rot_bits = DLY_W'({lfsr_reg, lfsr_reg} >> ROT);
      assign gap_new  = {1'b0, rot_bits & dly_mask} + (DLY_W+1)'(1);
      assign ack      = cmt_valid && (cmt_pc == ack_pc[gi*PC_W +: PC_W]);

      always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
          st_reg      <= ST_DISARM;
          gap_reg     <= '0;
          lat_reg     <= '0;
          lat_max_reg <= '0;
          cnt_reg     <= '0;
          irq_reg     <= 1'b0;
          tmo_reg     <= 1'b0;
        end else begin
          case (st_reg)
            ST_DISARM: begin
              if (armed_reg) begin
                st_reg  <= ST_WAIT;
                gap_reg <= gap_new;
              end
            end
            ST_WAIT: begin
              if (stop_req) begin
                st_reg <= ST_DONE;
              end else if (gap_reg == (DLY_W+1)'(1)) begin
                st_reg  <= ST_ASSERT;
                irq_reg <= 1'b1;
                lat_reg <= '0;
                if (cnt_reg != {CNT_W{1'b1}}) cnt_reg <= cnt_reg + CNT_W'(1);
              end else begin
                gap_reg <= gap_reg - (DLY_W+1)'(1);
              end
            end
            ST_ASSERT: begin
              // An ack landing on the timeout cycle counts as a normal completion.
              if (ack || (lat_reg == {LAT_W{1'b1}})) begin
                irq_reg <= 1'b0;
                if (ack) begin
                  if (lat_reg > lat_max_reg) lat_max_reg <= lat_reg;
                end else begin
                  tmo_reg <= 1'b1;
                end
                if (stop_req) begin
                  st_reg <= ST_DONE;
                end else begin
                  st_reg  <= ST_WAIT;
                  gap_reg <= gap_new;
                end
              end else begin
                lat_reg <= lat_reg + LAT_W'(1);
              end
            end
            default: st_reg <= ST_DONE;
          endcase
        end
      end

      assign irq_o[gi]                   = irq_reg;
      assign tmo_err[gi]                 = tmo_reg;
      assign inj_cnt[gi*CNT_W +: CNT_W]  = cnt_reg;
      assign lat_max[gi*LAT_W +: LAT_W]  = lat_max_reg;
      assign ch_idle[gi]                 = (st_reg == ST_DISARM) || (st_reg == ST_DONE);
    end
  endgenerate

  assign armed_o = armed_reg;
  assign idle_o  = (&ch_idle) && !(|irq_o);

endmodule

// File: tb/tb_e203_irq_stim_mon.sv
// Bench for e203_irq_stim_mon: timestamp-based reference model checked every cycle,
// plus directed arm/ack/timeout/stop/async-reset scenarios with literal expectations.
module tb_e203_irq_stim_mon;
  localparam int CH = 3, PC_W = 32, DLY_W = 10, LAT_W = 4, CNT_W = 16;
  localparam int TMO = (1 << LAT_W) - 1;

  logic                  hfclk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cmt_valid = 1'b0;
  logic [PC_W-1:0]       cmt_pc = '0;
  logic [PC_W-1:0]       arm_pc = 32'h8000015C;
  logic [CH*PC_W-1:0]    ack_pc = {32'h800000d6, 32'h800000be, 32'h800000a6};
  logic [DLY_W-1:0]      dly_mask = 10'h00f;
  logic                  stop_req = 1'b0;
  logic [CH-1:0]         irq_o;
  logic                  armed_o;
  logic                  idle_o;
  logic [CH*CNT_W-1:0]   inj_cnt;
  logic [CH*LAT_W-1:0]   lat_max;
  logic [CH-1:0]         tmo_err;

  e203_irq_stim_mon #(.CH_NUM(CH), .PC_W(PC_W), .DLY_W(DLY_W), .LAT_W(LAT_W),
                      .CNT_W(CNT_W), .SEED(32'h1)) dut (
    .hfclk(hfclk), .rst_n(rst_n), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .arm_pc(arm_pc), .ack_pc(ack_pc), .dly_mask(dly_mask), .stop_req(stop_req),
    .irq_o(irq_o), .armed_o(armed_o), .idle_o(idle_o), .inj_cnt(inj_cnt),
    .lat_max(lat_max), .tmo_err(tmo_err));

  always #5 hfclk = ~hfclk;

  int total = 0, bad = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: channel phase plus absolute cycle timestamps for the next/last rise.
  int          m_ph[CH];
  int          m_rise[CH];
  int          m_inj[CH];
  int          m_lmax[CH];
  bit          m_tmo[CH];
  bit          m_armed;
  logic [31:0] m_lfsr;
  int          m_lat;
  bit          m_ak;
  logic [CH-1:0]       e_irq, e_tmo;
  logic                e_idle;
  logic [CH*CNT_W-1:0] e_inj;
  logic [CH*LAT_W-1:0] e_lat;

  function automatic int gap_of(input logic [31:0] l, input int ch);
    int r;
    logic [31:0] rr;
    r  = (7 * ch) % 32;
    rr = (r == 0) ? l : ((l >> r) | (l << (32 - r)));
    return int'(rr & {22'b0, dly_mask}) + 1;
  endfunction

  always @(posedge hfclk) begin
    cyc++;
    if (!rst_n) begin
      m_armed = 1'b0;
      m_lfsr  = 32'h1;
      for (int ch = 0; ch < CH; ch++) begin
        m_ph[ch] = 0; m_rise[ch] = 0; m_inj[ch] = 0; m_lmax[ch] = 0; m_tmo[ch] = 1'b0;
      end
    end else begin
      for (int ch = 0; ch < CH; ch++) begin
        case (m_ph[ch])
          0: if (m_armed) begin
               m_ph[ch]   = 1;
               m_rise[ch] = cyc + gap_of(m_lfsr, ch);
             end
          1: if (stop_req) m_ph[ch] = 3;
             else if (cyc == m_rise[ch]) begin
               m_ph[ch]   = 2;
               m_rise[ch] = cyc;
               if (m_inj[ch] < (1 << CNT_W) - 1) m_inj[ch]++;
             end
          2: begin
               m_lat = cyc - 1 - m_rise[ch];
               m_ak  = cmt_valid && (cmt_pc == ack_pc[ch*PC_W +: PC_W]);
               if (m_ak || m_lat == TMO) begin
                 if (m_ak) begin
                   if (m_lat > m_lmax[ch]) m_lmax[ch] = m_lat;
                 end else m_tmo[ch] = 1'b1;
                 if (stop_req) m_ph[ch] = 3;
                 else begin
                   m_ph[ch]   = 1;
                   m_rise[ch] = cyc + gap_of(m_lfsr, ch);
                 end
               end
             end
          default: ;
        endcase
      end
      if (m_armed) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h80200003 : 32'h0);
      if (cmt_valid && cmt_pc == arm_pc) m_armed = 1'b1;
    end
    #1;
    e_idle = 1'b1;
    for (int ch = 0; ch < CH; ch++) begin
      e_irq[ch] = (m_ph[ch] == 2);
      e_tmo[ch] = m_tmo[ch];
      if (m_ph[ch] == 1 || m_ph[ch] == 2) e_idle = 1'b0;
      e_inj[ch*CNT_W +: CNT_W] = CNT_W'(m_inj[ch]);
      e_lat[ch*LAT_W +: LAT_W] = LAT_W'(m_lmax[ch]);
    end
    chk("m_irq", irq_o, e_irq);
    chk("m_armed", armed_o, m_armed);
    chk("m_idle", idle_o, e_idle);
    chk("m_inj", inj_cnt, e_inj);
    chk("m_lat", lat_max, e_lat);
    chk("m_tmo", tmo_err, e_tmo);
  end

  task automatic wait_rise(input int ch, input int limit);
    int k;
    k = 0;
    while (irq_o[ch] && k < limit) begin @(negedge hfclk); k++; end
    while (!irq_o[ch] && k < limit) begin @(negedge hfclk); k++; end
    chk($sformatf("wait_rise_ch%0d", ch), irq_o[ch], 1);
  endtask

  task automatic ack_now(input int ch);
    cmt_valid = 1'b1;
    cmt_pc    = ack_pc[ch*PC_W +: PC_W];
    @(negedge hfclk);
    cmt_valid = 1'b0;
  endtask

  int hi, k, inj1, min_e, iter;
  int edges[CH], lowrun[CH];
  bit seenfall[CH], prevb[CH], cur, found;

  initial begin
    repeat (30) @(negedge hfclk);
    chk("rst_irq", irq_o, 0);
    chk("rst_armed", armed_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_inj", inj_cnt, 0);
    chk("rst_lat", lat_max, 0);
    chk("rst_tmo", tmo_err, 0);
    rst_n = 1'b1;
    while (cyc < 50) @(negedge hfclk);
    chk("pre_arm", armed_o, 0);
    cmt_valid = 1'b1; cmt_pc = arm_pc;
    @(negedge hfclk);
    cmt_valid = 1'b0;
    chk("armed_51", armed_o, 1);
    chk("irq_51", irq_o, 0);
    @(negedge hfclk);
    chk("irq_52", irq_o, 0);

    // Ack 5 cycles after rise on channel 1.
    wait_rise(1, 200);
    repeat (5) @(negedge hfclk);
    ack_now(1);
    chk("ack_fall_ch1", irq_o[1], 0);
    chk("lat5_ch1", lat_max[1*LAT_W +: LAT_W], 5);
    chk("ack_tmo_ch1", tmo_err[1], 0);

    // Ack exactly on the timeout cycle: ack wins.
    wait_rise(1, 200);
    repeat (TMO) @(negedge hfclk);
    ack_now(1);
    chk("acktmo_fall_ch1", irq_o[1], 0);
    chk("acktmo_tmo_ch1", tmo_err[1], 0);
    chk("acktmo_lat_ch1", lat_max[1*LAT_W +: LAT_W], 15);

    // Unacked channel 0: high through latency 0..15, then timeout.
    wait_rise(0, 200);
    hi = 0;
    while (irq_o[0] && hi < 40) begin hi++; @(negedge hfclk); end
    chk("tmo_high_cycles", hi, 16);
    chk("tmo_err_ch0", tmo_err[0], 1);
    chk("tmo_lat_ch0", lat_max[0*LAT_W +: LAT_W], 0);

    // Stop while ch0 has just risen and ch1 is waiting.
    found = 0;
    prevb[0] = irq_o[0];
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge hfclk);
      if (irq_o[0] && !prevb[0] && !irq_o[1]) found = 1;
      prevb[0] = irq_o[0];
    end
    chk("stop_window", found, 1);
    stop_req = 1'b1;
    inj1 = int'(inj_cnt[1*CNT_W +: CNT_W]);
    @(negedge hfclk);
    chk("stop_hold_ch0", irq_o[0], 1);
    ack_now(0);
    chk("stop_ack_fall_ch0", irq_o[0], 0);
    k = 0;
    while (!idle_o && k < 40) begin @(negedge hfclk); k++; end
    chk("stop_idle", idle_o, 1);
    chk("stop_irq", irq_o, 0);
    chk("stop_inj_ch1", inj_cnt[1*CNT_W +: CNT_W], inj1);
    chk("stop_lat_ch0", lat_max[0*LAT_W +: LAT_W], 1);
    repeat (5) @(negedge hfclk);
    chk("done_stays_idle", idle_o, 1);
    stop_req = 1'b0;

    // Randomised run with gap-bound and edge-count tracking.
    rst_n = 1'b0;
    repeat (3) @(negedge hfclk);
    rst_n = 1'b1;
    cmt_valid = 1'b1; cmt_pc = arm_pc;
    @(negedge hfclk);
    cmt_valid = 1'b0;
    for (int ch = 0; ch < CH; ch++) begin
      edges[ch] = 0; lowrun[ch] = 0; seenfall[ch] = 0; prevb[ch] = 0;
    end
    iter = 0; min_e = 0;
    while (iter < 30000 && min_e < 200) begin
      @(negedge hfclk);
      iter++;
      min_e = 1 << 30;
      for (int ch = 0; ch < CH; ch++) begin
        cur = irq_o[ch];
        if (cur && !prevb[ch]) begin
          edges[ch]++;
          if (seenfall[ch])
            chk($sformatf("gap_range_ch%0d", ch), (lowrun[ch] >= 1 && lowrun[ch] <= 16), 1);
        end else if (!cur && prevb[ch]) begin
          seenfall[ch] = 1; lowrun[ch] = 0;
        end
        if (!cur) lowrun[ch]++;
        prevb[ch] = cur;
        if (edges[ch] < min_e) min_e = edges[ch];
      end
      cmt_valid = ($urandom_range(0, 3) == 0);
      k = $urandom_range(0, 3);
      cmt_pc = (k < CH) ? ack_pc[k*PC_W +: PC_W] : $urandom;
      if (iter == 2000) ack_pc[2*PC_W +: PC_W] = ack_pc[1*PC_W +: PC_W];
    end
    cmt_valid = 1'b0;
    chk("inj_200", (min_e >= 200), 1);
    for (int ch = 0; ch < CH; ch++)
      chk($sformatf("edge_cnt_ch%0d", ch), inj_cnt[ch*CNT_W +: CNT_W], edges[ch]);

    // Asynchronous reset while all lines are high.
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge hfclk);
      if (irq_o == 3'b111) found = 1;
    end
    chk("all_high_found", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_irq", irq_o, 0);
    chk("async_armed", armed_o, 0);
    chk("async_inj", inj_cnt, 0);
    repeat (3) @(negedge hfclk);
    rst_n = 1'b1;
    repeat (20) @(negedge hfclk);
    chk("rearm_wait_armed", armed_o, 0);
    chk("rearm_wait_irq", irq_o, 0);
    chk("rearm_wait_idle", idle_o, 1);
    cmt_valid = 1'b1; cmt_pc = arm_pc;
    @(negedge hfclk);
    cmt_valid = 1'b0;
    chk("rearm_armed", armed_o, 1);
    repeat (40) @(negedge hfclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
